// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: checker state encoding,
// standard polynomial tap pairs and a bit-count helper.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // Tap pairs (1-based) for the common ITU/IEEE PRBS polynomials.
  localparam int PRBS7_NB      = 7;
  localparam int PRBS7_TAP_HI  = 7;
  localparam int PRBS7_TAP_LO  = 6;
  localparam int PRBS9_NB      = 9;
  localparam int PRBS9_TAP_HI  = 9;
  localparam int PRBS9_TAP_LO  = 5;
  localparam int PRBS15_NB     = 15;
  localparam int PRBS15_TAP_HI = 15;
  localparam int PRBS15_TAP_LO = 14;
  localparam int PRBS23_NB     = 23;
  localparam int PRBS23_TAP_HI = 23;
  localparam int PRBS23_TAP_LO = 18;
  localparam int PRBS31_NB     = 31;
  localparam int PRBS31_TAP_HI = 31;
  localparam int PRBS31_TAP_LO = 28;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational NW-step Fibonacci LFSR advance; the first new bit lands in
// bits[NW-1], the last in bits[0].
module prbs_lfsr_step #(
  parameter int NB     = 9,
  parameter int TAP_HI = 9,
  parameter int TAP_LO = 5,
  parameter int NW     = 1
) (
  input  logic [NB-1:0] state,
  output logic [NB-1:0] next_state,
  output logic [NW-1:0] bits
);

  logic [NW:0][NB-1:0] chain;

  assign chain[0] = state;

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_step
      logic fb;
      assign fb            = chain[gi][TAP_HI-1] ^ chain[gi][TAP_LO-1];
      assign chain[gi+1]   = {chain[gi][NB-2:0], fb};
      assign bits[NW-1-gi] = fb;
    end
  endgenerate

  assign next_state = chain[NW];

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS word generator plus independent self-synchronising checker with lock
// detection and a saturating bit-error counter.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int          NB       = 9,
  parameter int          TAP_HI   = 9,
  parameter int          TAP_LO   = 5,
  parameter logic [NB-1:0] SEED   = 9'h1AA,
  parameter int          NW       = 1,
  parameter int          LOCK_CNT = 8,
  parameter int          LOSS_CNT = 4,
  parameter int          ECW      = 16
) (
  input  logic           clk,
  input  logic           i_reset,
  input  logic           i_enable,
  input  logic           i_valid,
  output logic [NW-1:0]  o_gen_data,
  output logic           o_gen_valid,
  input  logic [NW-1:0]  i_chk_data,
  input  logic           i_chk_valid,
  input  logic           i_clr_err,
  output logic           o_lock,
  output logic [ECW-1:0] o_err_cnt,
  output logic [1:0]     o_state
);

  localparam int FW = $clog2(NB + NW) + 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int SW = ECW + 7;
  localparam logic [ECW-1:0] ERR_MAX = {ECW{1'b1}};

  // ---------------- generator ----------------
  logic [NB-1:0] gen_lfsr_reg, gen_lfsr_next;
  logic [NW-1:0] gen_bits, gen_data_reg;
  logic          gen_valid_reg;

  prbs_lfsr_step #(.NB(NB), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO), .NW(NW)) u_gen_step (
    .state      (gen_lfsr_reg),
    .next_state (gen_lfsr_next),
    .bits       (gen_bits)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      gen_lfsr_reg  <= SEED;
      gen_data_reg  <= '0;
      gen_valid_reg <= 1'b0;
    end else if (i_enable && i_valid) begin
      gen_lfsr_reg  <= gen_lfsr_next;
      gen_data_reg  <= gen_bits;
      gen_valid_reg <= 1'b1;
    end else begin
      gen_valid_reg <= 1'b0;
    end
  end

  assign o_gen_data  = gen_data_reg;
  assign o_gen_valid = gen_valid_reg;

  // ---------------- checker ----------------
  chk_state_t     state_reg, state_next;
  logic [NB-1:0]  chk_lfsr_reg, chk_lfsr_next, chk_pred_state, chk_loaded;
  logic [NW-1:0]  chk_pred_bits, chk_diff;
  logic [FW-1:0]  fill_reg, fill_next;
  logic [MW-1:0]  match_reg, match_next;
  logic [LW-1:0]  loss_reg, loss_next;
  logic [ECW-1:0] err_cnt_reg, err_cnt_next, err_sat, word_clip;
  logic [SW-1:0]  err_sum, word_errs_w;
  logic [5:0]     word_errs;
  logic           lock_reg, chk_fire, counted;

  prbs_lfsr_step #(.NB(NB), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO), .NW(NW)) u_chk_step (
    .state      (chk_lfsr_reg),
    .next_state (chk_pred_state),
    .bits       (chk_pred_bits)
  );

  // Received bits enter at the LSB end, matching the generator's shift order.
  generate
    if (NW == NB) begin : g_load_full
      assign chk_loaded = i_chk_data;
    end else begin : g_load_shift
      assign chk_loaded = {chk_lfsr_reg[NB-NW-1:0], i_chk_data};
    end
  endgenerate

  assign chk_fire    = i_enable && i_chk_valid;
  assign chk_diff    = i_chk_data ^ chk_pred_bits;
  assign word_errs   = popcount(32'(chk_diff));
  assign word_errs_w = SW'(word_errs);
  assign err_sum     = SW'(err_cnt_reg) + word_errs_w;
  assign err_sat     = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ECW-1:0];
  assign word_clip   = (word_errs_w > SW'(ERR_MAX)) ? ERR_MAX : word_errs_w[ECW-1:0];

  always_comb begin
    state_next    = state_reg;
    chk_lfsr_next = chk_lfsr_reg;
    fill_next     = fill_reg;
    match_next    = match_reg;
    loss_next     = loss_reg;
    err_cnt_next  = err_cnt_reg;
    counted       = 1'b0;
    if (chk_fire) begin
      case (state_reg)
        ST_SEARCH: begin
          chk_lfsr_next = chk_loaded;
          if (fill_reg + FW'(NW) >= FW'(NB)) begin
            state_next = ST_VERIFY;
            fill_next  = '0;
          end else begin
            fill_next = fill_reg + FW'(NW);
          end
        end
        ST_VERIFY: begin
          chk_lfsr_next = chk_loaded;
          if (chk_diff != '0) begin
            state_next = ST_SEARCH;
            match_next = '0;
            fill_next  = '0;
          end else if (match_reg == MW'(LOCK_CNT - 1)) begin
            state_next = ST_LOCKED;
            match_next = '0;
          end else begin
            match_next = match_reg + MW'(1);
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so a single flipped bit counts once.
          chk_lfsr_next = chk_pred_state;
          counted       = 1'b1;
          err_cnt_next  = err_sat;
          if (chk_diff == '0) begin
            loss_next = '0;
          end else if (loss_reg == LW'(LOSS_CNT - 1)) begin
            state_next = ST_SEARCH;
            loss_next  = '0;
            fill_next  = '0;
          end else begin
            loss_next = loss_reg + LW'(1);
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
    if (i_clr_err) begin
      err_cnt_next = counted ? word_clip : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg    <= ST_SEARCH;
      chk_lfsr_reg <= '0;
      fill_reg     <= '0;
      match_reg    <= '0;
      loss_reg     <= '0;
      err_cnt_reg  <= '0;
      lock_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      chk_lfsr_reg <= chk_lfsr_next;
      fill_reg     <= fill_next;
      match_reg    <= match_next;
      loss_reg     <= loss_next;
      err_cnt_reg  <= err_cnt_next;
      lock_reg     <= (state_next == ST_LOCKED);
    end
  end

  assign o_lock    = lock_reg;
  assign o_err_cnt = err_cnt_reg;
  assign o_state   = state_reg;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: directed loopback scenarios plus randomized traffic,
// checked against a bit-history recurrence model of generator and checker.
module tb_prbs_gen_chk;

  localparam int NB = 9, TH = 9, TL = 5, LOCK_CNT = 8, LOSS_CNT = 4;
  localparam logic [NB-1:0] SEED = 9'h1AA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (NW=1, ECW=16)
  logic        rst, en, vld, chk_data, chk_valid, clr;
  logic        gen_data, gen_valid, lock;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  prbs_gen_chk dut (
    .clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld),
    .o_gen_data(gen_data), .o_gen_valid(gen_valid),
    .i_chk_data(chk_data), .i_chk_valid(chk_valid),
    .i_clr_err(clr), .o_lock(lock), .o_err_cnt(err_cnt), .o_state(state)
  );

  // wide-word, narrow-counter instance, looped back through an XOR injector
  logic       r4, en4, vld4, clr4, gv4, lk4;
  logic [3:0] inj4, gd4, ec4, chk4;
  logic [1:0] st4;
  assign chk4 = gd4 ^ inj4;

  prbs_gen_chk #(.NW(4), .ECW(4)) dut4 (
    .clk(clk), .i_reset(r4), .i_enable(en4), .i_valid(vld4),
    .o_gen_data(gd4), .o_gen_valid(gv4),
    .i_chk_data(chk4), .i_chk_valid(gv4),
    .i_clr_err(clr4), .o_lock(lk4), .o_err_cnt(ec4), .o_state(st4)
  );

  int checks = 0, errors = 0, txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit histories, newest bit at the back of each queue.
  bit          g_hist[$];
  bit          c_hist[$];
  bit          m_gdata, m_gvalid;
  int          m_state, m_fill, m_match, m_loss;
  int unsigned m_err;

  function automatic bit rec_next(input bit h[$]);
    return h[h.size()-TH] ^ h[h.size()-TL];
  endfunction

  function automatic logic [NB-1:0] pack(input bit h[$]);
    logic [NB-1:0] v;
    for (int k = 0; k < NB; k++) v[k] = h[h.size()-1-k];
    return v;
  endfunction

  function automatic void model_reset();
    g_hist.delete();
    c_hist.delete();
    for (int k = NB-1; k >= 0; k--) g_hist.push_back(SEED[k]);
    for (int k = 0; k < NB; k++) c_hist.push_back(1'b0);
    m_gdata = 0; m_gvalid = 0;
    m_state = 0; m_fill = 0; m_match = 0; m_loss = 0; m_err = 0;
  endfunction

  function automatic void model_chk(input bit d, output bit counted, output int unsigned werr);
    bit p;
    p = rec_next(c_hist);
    counted = 0;
    werr = 0;
    case (m_state)
      0: begin
        c_hist.push_back(d);
        m_fill++;
        if (m_fill >= NB) begin m_state = 1; m_fill = 0; end
      end
      1: begin
        c_hist.push_back(d);
        if (d != p) begin m_state = 0; m_match = 0; end
        else begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_state = 2; m_match = 0; end
        end
      end
      default: begin
        c_hist.push_back(p);
        counted = 1;
        werr = (d != p) ? 1 : 0;
        m_err = (m_err + werr > 65535) ? 65535 : m_err + werr;
        if (werr != 0) begin
          m_loss++;
          if (m_loss == LOSS_CNT) begin m_state = 0; m_loss = 0; end
        end else m_loss = 0;
      end
    endcase
    void'(c_hist.pop_front());
  endfunction

  // One clock of the main instance; checker input is the expected generator
  // word (external loopback) XOR an optional single-bit injection.
  task automatic step(input bit e, input bit v, input bit inj, input bit c);
    bit counted, nb;
    int unsigned werr;
    bit cd;
    counted = 0; werr = 0;
    cd = m_gdata ^ inj;
    en = e; vld = v; clr = c; chk_valid = m_gvalid; chk_data = cd;
    @(posedge clk); #1;
    if (e && m_gvalid) model_chk(cd, counted, werr);
    if (c) m_err = counted ? werr : 0;
    if (e && v) begin
      nb = rec_next(g_hist);
      g_hist.push_back(nb);
      void'(g_hist.pop_front());
      m_gdata = nb;
      m_gvalid = 1;
    end else m_gvalid = 0;
    txn++;
    $display("txn %0d en=%0b vld=%0b inj=%0b clr=%0b gen=%0b/%0b st=%0d lock=%0b err=%0d",
             txn, e, v, inj, c, gen_data, gen_valid, state, lock, err_cnt);
    check("gen_data", gen_data, m_gdata);
    check("gen_valid", gen_valid, m_gvalid);
    check("gen_lfsr", dut.gen_lfsr_reg, pack(g_hist));
    check("chk_lfsr", dut.chk_lfsr_reg, pack(c_hist));
    check("state", state, m_state);
    check("lock", lock, m_state == 2);
    check("err_cnt", err_cnt, m_err);
  endtask

  task automatic do_reset();
    rst = 1; en = 1; vld = 1; clr = 1; chk_valid = 1; chk_data = 1;
    @(posedge clk); #1;
    model_reset();
    rst = 0; en = 0; vld = 0; clr = 0; chk_valid = 0; chk_data = 0;
    txn++;
    $display("txn %0d reset st=%0d lock=%0b err=%0d", txn, state, lock, err_cnt);
    check("rst_gen_data", gen_data, 0);
    check("rst_gen_valid", gen_valid, 0);
    check("rst_lock", lock, 0);
    check("rst_state", state, 0);
    check("rst_err", err_cnt, 0);
    check("rst_gen_lfsr", dut.gen_lfsr_reg, 9'h1AA);
    check("rst_chk_lfsr", dut.chk_lfsr_reg, 0);
  endtask

  task automatic step4(input bit inj_all, input logic [3:0] pat, input bit c);
    en4 = 1; vld4 = 1; clr4 = c; inj4 = inj_all ? pat : 4'h0;
    @(posedge clk); #1;
    txn++;
    $display("txn %0d w4 inj=%0h clr=%0b st=%0d lock=%0b err=%0d", txn, inj4, c, st4, lk4, ec4);
  endtask

  int nwords, lock_at, gsteps;
  logic [NB-1:0] sv_g, sv_c;
  bit sv_gd;
  int sv_st;

  initial begin
    rst = 0; en = 0; vld = 0; chk_data = 0; chk_valid = 0; clr = 0;
    r4 = 1; en4 = 0; vld4 = 0; clr4 = 0; inj4 = 0;
    model_reset();

    do_reset();
    do_reset();

    // first generator step from seed
    step(1, 1, 0, 0);
    check("first_bit", gen_data, 1);
    check("first_lfsr", dut.gen_lfsr_reg, 9'h155);
    gsteps = 1;

    // clean loopback: lock time and sequence period
    nwords = 0; lock_at = 0;
    for (int i = 1; i < 520; i++) begin
      if (m_gvalid) nwords++;
      step(1, 1, 0, 0);
      gsteps++;
      if (gsteps == 511) check("period_511", dut.gen_lfsr_reg, 9'h1AA);
      if (lock && lock_at == 0) lock_at = nwords;
    end
    check("lock_words", lock_at, 17);
    check("clean_err", err_cnt, 0);

    // single flipped bit while locked
    step(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    check("single_flip_err", err_cnt, 1);
    check("single_flip_lock", lock, 1);

    // four consecutive errored words drop lock; then relock
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    check("loss3_lock", lock, 1);
    step(1, 1, 1, 0);
    check("loss4_lock", lock, 0);
    check("loss4_state", state, 0);
    nwords = 0; lock_at = 0;
    for (int i = 0; i < 40 && lock_at == 0; i++) begin
      if (m_gvalid) nwords++;
      step(1, 1, 0, 0);
      if (lock) lock_at = nwords;
    end
    check("relock_words", lock_at, 17);

    // pause with i_enable low
    step(1, 0, 0, 0);
    sv_g = pack(g_hist); sv_c = pack(c_hist); sv_gd = m_gdata; sv_st = m_state;
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom_range(1)), 0, 0);
      check("pause_valid", gen_valid, 0);
    end
    check("pause_lfsr", dut.gen_lfsr_reg, sv_g);
    check("pause_data", gen_data, sv_gd);
    check("pause_chk_lfsr", dut.chk_lfsr_reg, sv_c);
    check("pause_state", state, sv_st);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    check("resume_lock", lock, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(49) != 0, $urandom_range(9) < 7,
           $urandom_range(29) == 0, $urandom_range(99) == 0);
    end

    // relock, then reset while locked
    for (int i = 0; i < 300 && !(lock && m_state == 2); i++) step(1, 1, 0, 0);
    check("pre_reset_lock", lock, 1);
    do_reset();

    // NW=4, ECW=4 instance: saturation and clear-with-count
    @(posedge clk); #1;
    r4 = 0;
    check("w4_rst_valid", gv4, 0);
    check("w4_rst_err", ec4, 0);
    for (int i = 0; i < 40 && !lk4; i++) step4(0, 4'h0, 0);
    check("w4_lock", lk4, 1);
    for (int i = 0; i < 3; i++) step4(1, 4'hF, 0);
    check("w4_lock_after3", lk4, 1);
    step4(1, 4'hF, 0);
    check("w4_sat_err", ec4, 15);
    check("w4_lost_lock", lk4, 0);
    check("w4_state", st4, 0);
    for (int i = 0; i < 40 && !lk4; i++) step4(0, 4'h0, 0);
    check("w4_relock", lk4, 1);
    check("w4_err_held", ec4, 15);
    step4(1, 4'b0011, 1);
    check("w4_clr_load", ec4, 2);
    check("w4_clr_lock", lk4, 1);
    step4(0, 4'h0, 0);
    check("w4_after_clr", ec4, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter NB, 9, LFSR length in bits (7..31).
REQ-002 SHALL have parameter TAP_HI, 9, upper feedback tap, 1-based; equals NB.
REQ-003 SHALL have parameter TAP_LO, 5, lower feedback tap, 1-based (1..NB-1).
REQ-004 SHALL have parameter SEED, 9'h1AA, generator reset state; nonzero.
REQ-005 SHALL have parameter NW, 1, bits per word (1..NB).
REQ-006 SHALL have parameter LOCK_CNT, 8, consecutive error-free words needed to declare lock.
REQ-007 SHALL have parameter LOSS_CNT, 4, consecutive errored words needed to drop lock.
REQ-008 SHALL have parameter ECW, 16, error counter width.
REQ-009 SHALL have ports, in this order: clk input 1 clock; i_reset input 1 reset, synchronous, active-high.
REQ-010 SHALL have ports: i_enable input 1 global advance enable; i_valid input 1 generator request.
REQ-011 SHALL have ports: o_gen_data output NW generated word; o_gen_valid output 1 word qualifier.
REQ-012 SHALL have ports: i_chk_data input NW received word; i_chk_valid input 1 received-word qualifier.
REQ-013 SHALL have ports: i_clr_err input 1 error-counter clear; o_lock output 1 checker locked.
REQ-014 SHALL have ports: o_err_cnt output ECW saturating bit-error count; o_state output 2 checker state.

Function
REQ-015 SHALL compute one LFSR step as: new bit = s[TAP_HI-1] XOR s[TAP_LO-1]; s <= {s[NB-2:0], new bit}.
REQ-016 SHALL, when i_enable && i_valid, advance the generator NW steps in one cycle; the first new bit goes to o_gen_data[NW-1], the last to bit 0.
REQ-017 SHALL register o_gen_data and o_gen_valid with one-cycle latency; otherwise hold the LFSR, keep o_gen_data, and drive o_gen_valid=0.
REQ-018 SHALL process a checker word only when i_enable && i_chk_valid; all checker state holds otherwise.
REQ-019 SHALL implement checker FSM SEARCH(0), VERIFY(1), LOCKED(2), shown on o_state.
REQ-020 SHALL, in SEARCH, shift received bits into the checker LFSR; it moves to VERIFY once at least NB bits have been loaded since entry.
REQ-021 SHALL, in VERIFY, compare each word against the NW-step prediction, then load the received bits; a mismatch sends it to SEARCH with the fill count cleared; LOCK_CNT consecutive matches send it to LOCKED.
REQ-022 SHALL, in LOCKED, free-run the checker LFSR on its own prediction, never on received bits.
REQ-023 SHALL, in LOCKED, add the number of mismatched bits (0..NW) in each word to o_err_cnt, saturating at all-ones.
REQ-024 SHALL, in LOCKED, return to SEARCH after LOSS_CNT consecutive errored words; an error-free word clears the loss run.
REQ-025 SHALL drive o_lock=1 exactly while o_state==LOCKED, registered.
REQ-026 SHALL handle i_clr_err: the counter loads the current word's error count if one is counted in the same cycle, else 0; the clear applies in any state.
REQ-027 SHALL not count errors in SEARCH or VERIFY.
REQ-028 SHALL run the generator and checker independently; they may be looped back externally.

Reset
REQ-029 SHALL, on i_reset, set generator LFSR=SEED, o_gen_data=0, o_gen_valid=0, checker LFSR=0, fill/match/loss counters=0, state=SEARCH, o_lock=0, o_err_cnt=0.
REQ-030 SHALL give i_reset priority over i_enable, i_valid, i_chk_valid and i_clr_err; reset mid-lock drops o_lock the next cycle.

Structure
REQ-031 SHALL place in shared package prbs_pkg: the checker state enum with its encoding, default tap constants for PRBS7/9/15/23/31, and a popcount function.
REQ-032 SHALL use one combinational sub-module, prbs_lfsr_step (NB, TAP_HI, TAP_LO, NW), returning the next state and the NW output bits; it is instantiated by both generator and checker.

Verification
REQ-033 SHALL cover: NB=9, NW=1, reset, one cycle of i_enable=i_valid=1 -> next cycle o_gen_data=1, o_gen_valid=1, internal LFSR=0x155.
REQ-034 SHALL cover: generator looped to checker, NW=1, 520 valid cycles -> LOCKED after NB+LOCK_CNT=17 words; o_err_cnt=0; generator state returns to 0x1AA after 511 steps.
REQ-035 SHALL cover: locked loopback with a single bit flipped -> o_err_cnt=1 (not 3, since the checker free-runs), o_lock stays 1.
REQ-036 SHALL cover: locked, 4 consecutive corrupted words -> o_lock=0 one cycle after the 4th; o_state=SEARCH; relock after 17 clean words.
REQ-037 SHALL cover: ECW=4, NW=4, all-ones error injection -> o_err_cnt saturates at 15; i_clr_err with an errored word of 2 flipped bits -> o_err_cnt=2.
REQ-038 SHALL cover: i_enable=0 for 10 cycles mid-stream -> LFSR, o_gen_data and checker state unchanged, o_gen_valid=0; i_reset while locked -> all outputs at reset values next cycle.
